// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// No logic here; consumed by fifo_rd_skid and fifo_rd_adapter.
// Backpressure is not applicable to a package.
package fifo_pkg;

    localparam int DEF_WIDTH = 4;   // default data word width
    localparam int OCC_W     = 2;   // occupancy counter width (holds 0..3)
    localparam int DEPTH     = 3;   // buffer entries

    typedef logic [OCC_W-1:0] occ_t;
    typedef logic [1:0]       ptr_t;

    // Circular pointer increment over DEPTH entries.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// 3-entry in-order buffer that turns captured FIFO words into a valid/ready stream.
// Latency: a captured word is visible at the head the cycle after capture.
// Backpressure: holds the head while rd_rdy is low; the caller must not push when full.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic             xfer,
    output occ_t             occ
);

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    occ_t             occ_q;
    logic             push;

    // Flush blocks both the capture and the handshake of the flush cycle.
    assign push   = wr_vld && !flush;
    assign rd_vld = (occ_q != occ_t'(0));
    assign rd_dat = mem[rd_ptr];
    assign xfer   = rd_vld && rd_rdy && !flush;
    assign occ    = occ_q;

    // Pointer and occupancy bookkeeping; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (xfer) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, xfer})
                2'b10:   occ_q <= occ_q + occ_t'(1);
                2'b01:   occ_q <= occ_q - occ_t'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Word storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

endmodule

// File: rtl/fifo_rd_adapter.sv
// Converts a FIFO read port (1-cycle read latency) into a valid/ready stream with a transfer count.
// Latency: 2 cycles from fifo_rd_en to m_valid when the buffer is empty; 1 word/cycle sustained.
// Backpressure: pops only while buffered + in-flight words < 3, so m_ready never reaches fifo_rd_en combinationally.
module fifo_rd_adapter
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count
);

    localparam logic [OCC_W:0] DEPTH_L = DEPTH[OCC_W:0];
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             inflight;
    logic             run;
    logic             xfer;
    occ_t             occ;
    logic [OCC_W:0]   pending;
    logic [CNT_W-1:0] cnt_q;

    // Words already committed to the buffer: stored plus the one arriving this cycle.
    assign pending    = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    // run holds the pop off until the first edge after reset release.
    assign fifo_rd_en = run && !fifo_empty && !flush && (pending < DEPTH_L);
    assign rd_count   = cnt_q;

    // Pop tracking: fifo_data is valid the cycle after a sampled pop.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            run      <= 1'b0;
            inflight <= 1'b0;
        end else begin
            run      <= 1'b1;
            inflight <= fifo_rd_en;
        end
    end

    // Accepted-transfer counter, wraps naturally; flush-cycle handshakes are excluded by xfer.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    fifo_rd_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk    (rd_clk),
        .rst_n  (rd_rst),
        .flush  (flush),
        .wr_vld (inflight),
        .wr_dat (fifo_data),
        .rd_rdy (m_ready),
        .rd_vld (m_valid),
        .rd_dat (m_data),
        .xfer   (xfer),
        .occ    (occ)
    );

endmodule
